// File: rtl/vx_cache_bank_req_queue_if.sv
// Request bundle between dispatch and a cache bank. The same bundle type is
// used on both sides of the per-bank queue: the producer drives the master
// modport, and the consumer receives on the slave modport and returns ready.
interface vx_cache_bank_req_queue_if #(
  parameter int NUM_PORTS       = 1,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int WORD_SEL_WIDTH  = 2,
  parameter int WORD_SIZE       = 4,
  parameter int REQ_SEL_WIDTH   = 2,
  parameter int TAG_WIDTH       = 3
);
  logic                                valid;
  logic [NUM_PORTS-1:0]                pmask;
  logic                                rw;
  logic [LINE_ADDR_WIDTH-1:0]          addr;
  logic [NUM_PORTS*WORD_SEL_WIDTH-1:0] wsel;
  logic [NUM_PORTS*WORD_SIZE-1:0]      byteen;
  logic [NUM_PORTS*WORD_SIZE*8-1:0]    data;
  logic [NUM_PORTS*REQ_SEL_WIDTH-1:0]  idx;
  logic [NUM_PORTS*TAG_WIDTH-1:0]      tag;
  logic                                ready;

  modport master (
    output valid, pmask, rw, addr, wsel, byteen, data, idx, tag,
    input  ready
  );

  modport slave (
    input  valid, pmask, rw, addr, wsel, byteen, data, idx, tag,
    output ready
  );
endinterface

// File: rtl/vx_cache_bank_req_queue.sv
// Per-bank elastic request queue. Sits between the request dispatcher and one
// cache bank so bank stalls never reach the core-side ready combinationally:
// in_ready is a function of the held count (and reset) only.

// Small register-file slice: one write port, one asynchronous read port.
module vx_cache_bank_req_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Payload needs no reset: whether a slot is live is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

module vx_cache_bank_req_queue #(
  parameter int NUM_PORTS       = 1,
  parameter int LINE_ADDR_WIDTH = 26,
  parameter int WORD_SEL_WIDTH  = 2,
  parameter int WORD_SIZE       = 4,
  parameter int REQ_SEL_WIDTH   = 2,
  parameter int TAG_WIDTH       = 3,
  parameter int DEPTH           = 4,   // power of two, >= 2
  parameter int CTR_WIDTH       = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  vx_cache_bank_req_queue_if.slave      in_bus,
  vx_cache_bank_req_queue_if.master     out_bus,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
  output logic [CTR_WIDTH-1:0]          stall_cycles
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int WSW   = WORD_SEL_WIDTH;
  localparam int BEW   = WORD_SIZE;
  localparam int DW    = WORD_SIZE*8;
  localparam int RSW   = REQ_SEL_WIDTH;
  localparam int TW    = TAG_WIDTH;

  // Fields shared by all ports of one request.
  typedef struct packed {
    logic [NUM_PORTS-1:0]       pmask;
    logic                       rw;
    logic [LINE_ADDR_WIDTH-1:0] addr;
  } hdr_req_t;

  // Fields carried per port.
  typedef struct packed {
    logic [WSW-1:0] wsel;
    logic [BEW-1:0] byteen;
    logic [DW-1:0]  data;
    logic [RSW-1:0] idx;
    logic [TW-1:0]  tag;
  } port_req_t;

  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CTR_WIDTH-1:0] stall_q, stall_d;
  logic                 push, pop;

  // Ready looks only at stored state, never at out_ready, so there is no
  // combinational path from the bank back to dispatch.
  assign in_bus.ready  = (count_q != CNT_W'(DEPTH)) && !reset;
  // Gating by reset blanks the head as soon as reset is sampled high.
  assign out_bus.valid = (count_q != '0) && !reset;

  assign push = in_bus.valid && in_bus.ready;
  assign pop  = out_bus.valid && out_bus.ready;

  assign occupancy    = reset ? '0 : count_q;
  assign stall_cycles = reset ? '0 : stall_q;

  // Header storage: one entry per slot, written and read as a unit with the
  // per-port lanes so a request is never split.
  hdr_req_t wr_hdr, rd_hdr;
  assign wr_hdr = '{pmask: in_bus.pmask, rw: in_bus.rw, addr: in_bus.addr};

  vx_cache_bank_req_queue_ram #(.DEPTH(DEPTH), .WIDTH($bits(hdr_req_t))) u_hdr (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_hdr),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_hdr)
  );

  assign out_bus.pmask = rd_hdr.pmask;
  assign out_bus.rw    = rd_hdr.rw;
  assign out_bus.addr  = rd_hdr.addr;

  // One storage lane per port, all sharing the same pointers.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_lane
    port_req_t wr_port, rd_port;
    assign wr_port = '{
      wsel:   in_bus.wsel[p*WSW +: WSW],
      byteen: in_bus.byteen[p*BEW +: BEW],
      data:   in_bus.data[p*DW +: DW],
      idx:    in_bus.idx[p*RSW +: RSW],
      tag:    in_bus.tag[p*TW +: TW]
    };

    vx_cache_bank_req_queue_ram #(.DEPTH(DEPTH), .WIDTH($bits(port_req_t))) u_lane (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_port),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_port)
    );

    assign out_bus.wsel[p*WSW +: WSW]   = rd_port.wsel;
    assign out_bus.byteen[p*BEW +: BEW] = rd_port.byteen;
    assign out_bus.data[p*DW +: DW]     = rd_port.data;
    assign out_bus.idx[p*RSW +: RSW]    = rd_port.idx;
    assign out_bus.tag[p*TW +: TW]      = rd_port.tag;
  end

  // Next-state for pointers, count and the stall counter.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (out_bus.valid && !out_bus.ready) stall_d = stall_q + CTR_WIDTH'(1);
  end

  // Control state register; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  // Protocol checks on the dispatch side and internal count sanity.
  a_pmask_nonzero: assert property (@(posedge clk) disable iff (reset)
    in_bus.valid |-> (in_bus.pmask != '0));

  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (in_bus.valid && !in_bus.ready) |=> (in_bus.valid &&
      $stable({in_bus.pmask, in_bus.rw, in_bus.addr, in_bus.wsel,
               in_bus.byteen, in_bus.data, in_bus.idx, in_bus.tag})));

  a_count_bound: assert property (@(posedge clk) count_q <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_vx_cache_bank_req_queue.sv
// Directed bench for the per-bank request queue. A monitor pushes every
// accepted request into a scoreboard queue and compares it against the head
// entry whenever the bank side pops; directed checks cover ready/occupancy/
// stall behaviour at fixed cycles.
module tb_vx_cache_bank_req_queue;
  localparam int NP    = 2;
  localparam int AW    = 26;
  localparam int WSW   = 2;
  localparam int WS    = 4;
  localparam int RSW   = 2;
  localparam int TW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 32;
  localparam int CNTW  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [NP-1:0]      pmask;
    logic               rw;
    logic [AW-1:0]      addr;
    logic [NP*WSW-1:0]  wsel;
    logic [NP*WS-1:0]   byteen;
    logic [NP*WS*8-1:0] data;
    logic [NP*RSW-1:0]  idx;
    logic [NP*TW-1:0]   tag;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic [CNTW-1:0] occupancy;
  logic [CW-1:0]   stall_cycles;

  int checks = 0;
  int fails  = 0;
  ent_t exp_q[$];

  always #5 clk = ~clk;

  vx_cache_bank_req_queue_if #(.NUM_PORTS(NP), .LINE_ADDR_WIDTH(AW), .WORD_SEL_WIDTH(WSW),
    .WORD_SIZE(WS), .REQ_SEL_WIDTH(RSW), .TAG_WIDTH(TW)) in_bus ();
  vx_cache_bank_req_queue_if #(.NUM_PORTS(NP), .LINE_ADDR_WIDTH(AW), .WORD_SEL_WIDTH(WSW),
    .WORD_SIZE(WS), .REQ_SEL_WIDTH(RSW), .TAG_WIDTH(TW)) out_bus ();

  vx_cache_bank_req_queue #(.NUM_PORTS(NP), .LINE_ADDR_WIDTH(AW), .WORD_SEL_WIDTH(WSW),
    .WORD_SIZE(WS), .REQ_SEL_WIDTH(RSW), .TAG_WIDTH(TW), .DEPTH(DEPTH), .CTR_WIDTH(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_bus       (in_bus.slave),
    .out_bus      (out_bus.master),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  function automatic ent_t mk(input logic [NP-1:0] pm, input logic rw,
                              input logic [AW-1:0] addr, input logic [TW-1:0] tag);
    ent_t e;
    e.pmask  = pm;
    e.rw     = rw;
    e.addr   = addr;
    e.wsel   = {2'(addr + 26'd1), 2'(addr)};
    e.byteen = {4'hF, 4'(addr)};
    e.data   = {32'hA5A5_0100 + 32'(addr), 32'hA5A5_0000 + 32'(addr)};
    e.idx    = {2'd2, 2'd1};
    e.tag    = {~tag, tag};
    return e;
  endfunction

  function automatic ent_t in_ent();
    ent_t e;
    e.pmask = in_bus.pmask; e.rw = in_bus.rw; e.addr = in_bus.addr; e.wsel = in_bus.wsel;
    e.byteen = in_bus.byteen; e.data = in_bus.data; e.idx = in_bus.idx; e.tag = in_bus.tag;
    return e;
  endfunction

  function automatic ent_t out_ent();
    ent_t e;
    e.pmask = out_bus.pmask; e.rw = out_bus.rw; e.addr = out_bus.addr; e.wsel = out_bus.wsel;
    e.byteen = out_bus.byteen; e.data = out_bus.data; e.idx = out_bus.idx; e.tag = out_bus.tag;
    return e;
  endfunction

  task automatic drive(input ent_t e, input logic v);
    in_bus.valid = v; in_bus.pmask = e.pmask; in_bus.rw = e.rw; in_bus.addr = e.addr;
    in_bus.wsel = e.wsel; in_bus.byteen = e.byteen; in_bus.data = e.data;
    in_bus.idx = e.idx; in_bus.tag = e.tag;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Scoreboard monitor: compare on pop first (no bypass), then record pushes.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (reset) exp_q.delete();
      else begin
        if (out_bus.valid && out_bus.ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected got=%h exp=none", out_ent());
          end else begin
            ent_t e;
            e = exp_q.pop_front();
            if (out_ent() !== e) begin
              fails++;
              $display("FAIL sb_entry got=%h exp=%h", out_ent(), e);
            end
          end
        end
        if (in_bus.valid && in_bus.ready) exp_q.push_back(in_ent());
      end
    end
  endtask

  // Present a request and hold it until accepted (bounded).
  task automatic send(input ent_t e, input bit rnd);
    int n = 0;
    drive(e, 1'b1);
    while (!in_bus.ready && n <= 50) begin
      if (rnd) out_bus.ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    checks++;
    if (n > 50) begin
      fails++;
      $display("FAIL send_timeout got=%0d exp<=50", n);
    end
    if (rnd) out_bus.ready = 1'($urandom_range(0, 1));
    tick();
    in_bus.valid = 1'b0;
  endtask

  // Pop until empty (bounded).
  task automatic drain(input bit rnd);
    int n = 0;
    while (out_bus.valid && n < 200) begin
      out_bus.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("drain_empty", 64'(out_bus.valid), 0);
    out_bus.ready = 1'b0;
  endtask

  task automatic do_reset();
    in_bus.valid = 1'b0; out_bus.ready = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    drive(mk(2'b01, 1'b0, '0, '0), 1'b0);
    out_bus.ready = 1'b0;
    reset = 1'b1;
    fork monitor(); join_none

    // Reset state
    tick(); tick();
    chk("rst_in_ready",  64'(in_bus.ready), 0);
    chk("rst_out_valid", 64'(out_bus.valid), 0);
    chk("rst_occupancy", 64'(occupancy), 0);

    // Single push, then stall counting
    reset = 1'b0; #1;
    chk("t1_in_ready",  64'(in_bus.ready), 1);
    chk("t1_out_valid", 64'(out_bus.valid), 0);
    chk("t1_occ0",      64'(occupancy), 0);
    drive(mk(2'b01, 1'b0, 26'h3A, 3'd5), 1'b1);
    tick(); in_bus.valid = 1'b0;
    chk("t1_valid",  64'(out_bus.valid), 1);
    chk("t1_addr",   64'(out_bus.addr), 64'h3A);
    chk("t1_tag",    64'(out_bus.tag[TW-1:0]), 5);
    chk("t1_occ1",   64'(occupancy), 1);
    chk("t1_stall0", 64'(stall_cycles), 0);
    tick(); chk("t1_stall1", 64'(stall_cycles), 1);
    tick(); chk("t1_stall2", 64'(stall_cycles), 2);
    out_bus.ready = 1'b1;
    tick(); out_bus.ready = 1'b0;
    chk("t1_empty",  64'(out_bus.valid), 0);
    chk("t1_occ_e",  64'(occupancy), 0);
    chk("t1_stallk", 64'(stall_cycles), 2);

    // Fill to full, hold a fifth, then drain in order
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(mk(2'b11, 1'b1, 26'(i), 3'(i)), 1'b1);
      tick();
    end
    chk("t2_full_rdy", 64'(in_bus.ready), 0);
    chk("t2_full_occ", 64'(occupancy), 4);
    drive(mk(2'b01, 1'b0, 26'd5, 3'd5), 1'b1);
    tick();
    chk("t2_held_rdy", 64'(in_bus.ready), 0);
    out_bus.ready = 1'b1;
    chk("t2_pop_rdy", 64'(in_bus.ready), 0);
    tick();
    chk("t2_rdy_back", 64'(in_bus.ready), 1);
    chk("t2_occ3",     64'(occupancy), 3);
    tick(); in_bus.valid = 1'b0;
    chk("t2_occ3b",    64'(occupancy), 3);
    drain(1'b0);

    // Continuous streaming
    do_reset();
    out_bus.ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(mk(2'b01, 1'b0, 26'h10 + 26'(k), 3'(k)), 1'b1);
      if (k > 0) begin
        chk("t3_occ",   64'(occupancy), 1);
        chk("t3_valid", 64'(out_bus.valid), 1);
        chk("t3_addr",  64'(out_bus.addr), 64'h10 + 64'(k) - 1);
      end
      tick();
    end
    in_bus.valid = 1'b0;
    chk("t3_last_occ",  64'(occupancy), 1);
    chk("t3_last_addr", 64'(out_bus.addr), 64'h23);
    tick();
    chk("t3_empty", 64'(out_bus.valid), 0);
    chk("t3_stall", 64'(stall_cycles), 0);
    out_bus.ready = 1'b0;

    // Pointer wrap with random bank ready and varied per-port fields
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ent_t e;
      e.pmask  = (i % 3 == 0) ? 2'b11 : (i % 3 == 1) ? 2'b01 : 2'b10;
      e.rw     = 1'(i);
      e.addr   = 26'h100 + 26'(i);
      e.wsel   = 4'(i);
      e.byteen = {4'(~i), 4'(i)};
      e.data   = {32'hA5A5_0100 + 32'(i), 32'hA5A5_0000 + 32'(i)};
      e.idx    = 4'(i * 3);
      e.tag    = 6'(i * 5);
      send(e, 1'b1);
    end
    drain(1'b1);

    // Reset while holding three entries
    do_reset();
    for (int i = 0; i < 3; i++) send(mk(2'b01, 1'b0, 26'h30 + 26'(i), 3'(i)), 1'b0);
    chk("t5_occ3", 64'(occupancy), 3);
    reset = 1'b1; #1;
    chk("t5_r_valid", 64'(out_bus.valid), 0);
    chk("t5_r_occ",   64'(occupancy), 0);
    chk("t5_r_stall", 64'(stall_cycles), 0);
    chk("t5_r_rdy",   64'(in_bus.ready), 0);
    tick(); reset = 1'b0; #1;
    chk("t5_a_valid", 64'(out_bus.valid), 0);
    chk("t5_a_occ",   64'(occupancy), 0);
    chk("t5_a_stall", 64'(stall_cycles), 0);
    chk("t5_a_rdy",   64'(in_bus.ready), 1);
    send(mk(2'b01, 1'b0, 26'h7, 3'd7), 1'b0);
    chk("t5_first", 64'(out_bus.addr), 64'h7);
    drain(1'b0);

    // Full with a simultaneous pop
    do_reset();
    for (int i = 0; i < 4; i++) send(mk(2'b10, 1'b1, 26'h20 + 26'(i), 3'(i)), 1'b0);
    drive(mk(2'b11, 1'b1, 26'h24, 3'd4), 1'b1);
    out_bus.ready = 1'b1;
    chk("t6_rdy_full", 64'(in_bus.ready), 0);
    chk("t6_occ4",     64'(occupancy), 4);
    tick(); out_bus.ready = 1'b0;
    chk("t6_occ3",   64'(occupancy), 3);
    chk("t6_rdy_up", 64'(in_bus.ready), 1);
    tick(); in_bus.valid = 1'b0;
    chk("t6_occ4b",  64'(occupancy), 4);
    chk("t6_rdy_dn", 64'(in_bus.ready), 0);
    drain(1'b0);

    tick(); tick();
    chk("sb_left", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/vx_cache_bank_req_queue.md
Name: vx_cache_bank_req_queue

Overview:
- Per-bank elastic request queue between the cache request dispatcher and one cache bank; one instance per bank.
- Accepts the per-bank request bundle produced by dispatch: valid, port mask, rw, line address, per-port wsel/byteen/data/idx/tag.
- Decouples bank pipeline stalls from the core-side dispatch timing.
- Its input ready is registered-state only, which removes the combinational path from bank ready back to core_req_ready.

Parameters:
- NUM_PORTS, 1, ports per bank; width of pmask.
- LINE_ADDR_WIDTH, 26, line address bits.
- WORD_SEL_WIDTH, 2, word-select bits per port.
- WORD_SIZE, 4, bytes per word; byteen width.
- REQ_SEL_WIDTH, 2, core request index bits per port.
- TAG_WIDTH, 3, core request tag bits per port.
- DEPTH, 4, queue entries; power of two, at least 2.
- CTR_WIDTH, 32, width of the stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid from dispatch.
- in_pmask  in  NUM_PORTS  active ports.
- in_rw  in  1  1=write.
- in_addr  in  LINE_ADDR_WIDTH  line address.
- in_wsel  in  NUM_PORTS*WORD_SEL_WIDTH  word select per port.
- in_byteen  in  NUM_PORTS*WORD_SIZE  byte enables per port.
- in_data  in  NUM_PORTS*WORD_SIZE*8  write data per port.
- in_idx  in  NUM_PORTS*REQ_SEL_WIDTH  originating core request index per port.
- in_tag  in  NUM_PORTS*TAG_WIDTH  tag per port.
- in_ready  out  1  queue can accept.
- out_valid, out_pmask, out_rw, out_addr, out_wsel, out_byteen, out_data, out_idx, out_tag  out  same widths as the in_* fields  head entry to bank.
- out_ready  in  1  bank accepts the head entry.
- occupancy  out  clog2(DEPTH+1)  entries held.
- stall_cycles  out  CTR_WIDTH  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Clock and reset (already decided): single clock clk; reset is synchronous and active-high.
- Reset clears rd_ptr, wr_ptr, count and stall_cycles to 0. During reset and on the first cycle after it: out_valid=0, occupancy=0. in_ready=0 while reset is high and 1 on the first cycle after it.
- Payload fields are don't-care when out_valid=0. No storage reset is needed.
- Push is in_valid && in_ready. Pop is out_valid && out_ready.
- in_ready = (count != DEPTH) && !reset. It must not depend on out_ready.
- out_valid = (count != 0). The out_* payload is the storage entry at rd_ptr.
- Latency: an entry pushed in cycle N is presented at the earliest in cycle N+1. There is no same-cycle bypass.
- Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally. count is clog2(DEPTH+1) bits.
- Push only: write storage[wr_ptr], wr_ptr++, count++.
- Pop only: rd_ptr++, count--.
- Push and pop in the same cycle with 0<count<DEPTH: both pointers advance and count is unchanged.
- Full (count=DEPTH): in_ready=0. A pop in this cycle frees a slot, and in_ready rises in the next cycle.
- Empty (count=0): out_valid=0. out_ready is ignored.
- Ordering is strict FIFO. All fields of one request travel as a single atomic entry and are never split across ports.
- occupancy = count, registered.
- stall_cycles increments by 1 each cycle with out_valid && !out_ready. It wraps modulo 2^CTR_WIDTH.
- Reset asserted mid-operation discards all entries. No output toggles spuriously: out_valid is 0 from the first cycle reset is sampled high.
- Assertions (simulation only):
  - in_valid && in_pmask==0 is illegal.
  - in_* must be stable while in_valid && !in_ready.
  - count must never exceed DEPTH.

Test Plan:
- Reset then single push: addr=0x3A, rw=0, pmask=1, tag=5 in cycle 1 with out_ready=0 -> cycle 2: out_valid=1, out_addr=0x3A, out_tag=5, occupancy=1; stall_cycles counts 1 per cycle from cycle 2.
- Fill to full with DEPTH=4 and out_ready=0: push addr 1,2,3,4 -> in_ready=0 after the 4th push, occupancy=4. A 5th in_valid with addr=5 is held and not lost. Then set out_ready=1 -> outputs appear in order 1,2,3,4,5; in_ready returns 1 the cycle after the first pop.
- Continuous streaming with in_valid=1 and out_ready=1 for 20 cycles, addr incrementing from 0x10 -> occupancy stays at 1 after the first cycle. Outputs are 0x10..0x23 in order with no gaps, and stall_cycles=0.
- Pointer wrap: 10 push/pop rounds over DEPTH=4 with random out_ready and NUM_PORTS=2, per-port data 0xA5A5_0000+i -> the scoreboard matches every field of every entry, and the pmask 2'b10 entry is reproduced exactly.
- Reset mid-operation with 3 entries held: assert reset for 1 cycle -> in that cycle and after it out_valid=0, occupancy=0, stall_cycles=0. The next push, addr=0x7, emerges first.
- Full with simultaneous pop: at count=4 with out_ready=1 and in_valid=1 -> in_ready=0 in that cycle and count=3 in the next. The held request is accepted in the next cycle, giving count=4 when out_ready=0.
